uart_rx_vote_sampler: RTL and testbench

Parametrised oversampling data sampler for the UART receive path. It synchronises `RX_IN` and takes an odd number (3, 5 or 7) of samples centred on the middle of each bit period, as set by `prescale`. For each bit it outputs a majority-voted bit with a one-cycle valid strobe, plus a noise flag when the samples disagree. It sits between the edge/bit counter (source of `edge_count`) and the deserializer/FSM, which consume `sampled_data` on `sample_valid`.

---
 rtl/uart_rx_vote_sampler.sv | 124 ++++++++++++
 tb/tb_uart_rx_vote_sampler.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_vote_sampler.sv
// Oversampling majority-vote bit sampler for the UART receive path.
// Takes NUM_SAMPLES synchronised samples centred on each bit and strobes out the voted bit plus a noise flag.
module uart_rx_vote_sampler #(
    parameter int PRESCALE_W  = 6,
    parameter int NUM_SAMPLES = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_based_on_prescale,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  RX_IN,
    input  logic                  data_sampler_enable,
    input  logic [PRESCALE_W-1:0] edge_count,
    output logic                  sampled_data,
    output logic                  sample_valid,
    output logic                  noise_error,
    output logic                  cfg_error
);

    localparam int K      = (NUM_SAMPLES - 1) / 2;
    localparam int ONES_W = $clog2(NUM_SAMPLES + 1);

    localparam logic [PRESCALE_W-1:0] PS_RESET = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] MIN_PS   = PRESCALE_W'(2 * K + 2);
    localparam logic [PRESCALE_W-1:0] K_PS     = PRESCALE_W'(K);
    localparam logic [ONES_W-1:0]     K_ONES   = ONES_W'(K);
    localparam logic [ONES_W-1:0]     N_ONES   = ONES_W'(NUM_SAMPLES);
    localparam logic [ONES_W-1:0]     N_M1     = ONES_W'(NUM_SAMPLES - 1);

    logic rx_s;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign rx_s = RX_IN;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge clk_based_on_prescale) begin
                if (rst) begin
                    sync_q <= '1;
                end else begin
                    sync_q[0] <= RX_IN;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end

            assign rx_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [PRESCALE_W-1:0]  lat_ps;
    logic                   en_q;
    logic [NUM_SAMPLES-1:0] samp;
    logic [ONES_W-1:0]      ones;
    logic [ONES_W-1:0]      n_cap;

    logic [PRESCALE_W-1:0]  mid, first, last;
    logic                   cfg_bad, capture, at_first, at_last, window_done;
    logic [ONES_W-1:0]      rx_ext, ones_next;
    logic [NUM_SAMPLES-1:0] samp_next;

    assign mid      = lat_ps >> 1;
    assign first    = mid - K_PS;
    assign last     = mid + K_PS;
    // Gate on the live comparison so a freshly latched bad prescale never captures
    // during the cycle before cfg_error itself is registered.
    assign cfg_bad  = (lat_ps < MIN_PS);
    assign at_first = (edge_count == first);
    assign at_last  = (edge_count == last);
    assign capture  = data_sampler_enable && !cfg_bad
                      && (edge_count >= first) && (edge_count <= last);

    assign rx_ext    = {{(ONES_W-1){1'b0}}, rx_s};
    assign ones_next = at_first ? rx_ext : ones + rx_ext;
    assign samp_next = {samp[NUM_SAMPLES-2:0], rx_s};

    // n_cap proves every sample of this window was taken; interrupted or skipped windows never strobe.
    assign window_done = capture && at_last && (n_cap == N_M1);

    // NOTE: all state uses non-blocking assignment so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_based_on_prescale) begin
        if (rst) begin
            lat_ps       <= PS_RESET;
            en_q         <= 1'b0;
            samp         <= '0;
            ones         <= '0;
            n_cap        <= '0;
            cfg_error    <= 1'b0;
            sampled_data <= 1'b1;
            sample_valid <= 1'b0;
            noise_error  <= 1'b0;
        end else begin
            en_q      <= data_sampler_enable;
            cfg_error <= cfg_bad;

            if (data_sampler_enable && (edge_count == '0 || !en_q))
                lat_ps <= prescale;

            sample_valid <= window_done;
            noise_error  <= window_done && (ones_next != '0) && (ones_next != N_ONES);
            if (window_done)
                sampled_data <= (ones_next > K_ONES);

            if (!data_sampler_enable) begin
                samp  <= '0;
                ones  <= '0;
                n_cap <= '0;
            end else if (capture) begin
                samp  <= samp_next;
                ones  <= ones_next;
                n_cap <= at_first ? ONES_W'(1) : n_cap + ONES_W'(1);
            end else begin
                n_cap <= '0;
            end
        end
    end

    // The running count must always agree with the sample shift register when a vote is taken.
    always @(posedge clk_based_on_prescale) begin
        if (!rst && window_done)
            assert ($countones(samp_next) == int'(ones_next));
    end

endmodule

// File: tb/tb_uart_rx_vote_sampler.sv
// Scoreboard bench for uart_rx_vote_sampler: a 3-sample and a 5-sample instance share the line,
// expected votes are computed from the driven line pattern and popped when each strobe appears.
module tb_uart_rx_vote_sampler;

    typedef struct {
        logic data;
        logic noise;
        int   edge_at;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       rx_in = 1'b1;
    logic       en3 = 1'b0;
    logic       en5 = 1'b0;
    logic [5:0] edge_count = '0;

    logic sd3, sv3, ne3, cfg3;
    logic sd5, sv5, ne5, cfg5;

    exp_t sb3[$];
    exp_t sb5[$];

    int n_checks = 0;
    int n_pass   = 0;

    uart_rx_vote_sampler dut3 (
        .clk_based_on_prescale(clk),
        .rst                  (rst),
        .prescale             (prescale),
        .RX_IN                (rx_in),
        .data_sampler_enable  (en3),
        .edge_count           (edge_count),
        .sampled_data         (sd3),
        .sample_valid         (sv3),
        .noise_error          (ne3),
        .cfg_error            (cfg3)
    );

    uart_rx_vote_sampler #(.NUM_SAMPLES(5)) dut5 (
        .clk_based_on_prescale(clk),
        .rst                  (rst),
        .prescale             (prescale),
        .RX_IN                (rx_in),
        .data_sampler_enable  (en5),
        .edge_count           (edge_count),
        .sampled_data         (sd5),
        .sample_valid         (sv5),
        .noise_error          (ne5),
        .cfg_error            (cfg5)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // One bit period. pat[i] is the synchronised line value wanted at edge i; RX_IN is driven
    // two clocks early to cover the synchroniser.
    task automatic run_bit(input int ps, input logic [31:0] pat, input bit use5,
                           input int drop_edge, input int rst_edge,
                           input int probe_edge, input logic probe_cfg);
        int   k, n, first, last, ones;
        exp_t e;
        k     = use5 ? 2 : 1;
        n     = 2 * k + 1;
        first = ps / 2 - k;
        last  = ps / 2 + k;
        ones  = 0;
        if (ps >= 2 * k + 2 && drop_edge < 0 && rst_edge < 0) begin
            for (int i = first; i <= last; i++) ones += int'(pat[i]);
            e.data    = (ones > k);
            e.noise   = (ones != 0) && (ones != n);
            e.edge_at = (last + 1) % ps;
            if (use5) sb5.push_back(e);
            else      sb3.push_back(e);
        end
        for (int ec = 0; ec < ps; ec++) begin
            @(posedge clk);
            #1;
            edge_count = 6'(ec);
            prescale   = 6'(ps);
            rx_in      = (ec + 2 < ps) ? pat[ec + 2] : 1'b1;
            rst        = (ec == rst_edge);
            en3        = !use5 && (ec != drop_edge);
            en5        = use5 && (ec != drop_edge);
            if (ec == probe_edge) begin
                @(negedge clk);
                check(use5 ? "cfg_error5" : "cfg_error3", use5 ? cfg5 : cfg3, probe_cfg);
            end
            if (rst_edge >= 0 && ec == rst_edge + 1) begin
                @(negedge clk);
                check("rst_sampled_data", sd3, 1'b1);
                check("rst_sample_valid", sv3, 1'b0);
                check("rst_noise_error", ne3, 1'b0);
                check("rst_cfg_error", cfg3, 1'b0);
            end
            if (rst_edge >= 0 && ec == rst_edge + 2) begin
                @(negedge clk);
                check("rst_no_strobe", sv3, 1'b0);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (sv3) begin
                if (sb3.size() == 0) begin
                    check("strobe3_unexpected", sv3, 1'b0);
                end else begin
                    exp_t e;
                    e = sb3.pop_front();
                    check("data3", sd3, e.data);
                    check("noise3", ne3, e.noise);
                    check("latency3", edge_count, e.edge_at);
                end
            end else if (ne3) begin
                check("noise3_idle", ne3, 1'b0);
            end
            if (sv5) begin
                if (sb5.size() == 0) begin
                    check("strobe5_unexpected", sv5, 1'b0);
                end else begin
                    exp_t e;
                    e = sb5.pop_front();
                    check("data5", sd5, e.data);
                    check("noise5", ne5, e.noise);
                    check("latency5", edge_count, e.edge_at);
                end
            end else if (ne5) begin
                check("noise5_idle", ne5, 1'b0);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_sampled_data", sd3, 1'b1);
        check("reset_sample_valid", sv3, 1'b0);
        check("reset_noise_error", ne3, 1'b0);
        check("reset_cfg_error", cfg3, 1'b0);
        check("reset_sampled_data5", sd5, 1'b1);

        // 3-sample instance, prescale 8: window is edges 3..5
        run_bit(8, 32'h0000_0028, 1'b0, -1, -1, -1, 1'b0);  // 1,0,1
        run_bit(8, 32'h0000_0020, 1'b0, -1, -1, -1, 1'b0);  // 0,0,1
        run_bit(8, 32'hFFFF_FFFF, 1'b0, -1, -1, -1, 1'b0);  // clean 1
        run_bit(8, 32'hFFFF_FFC7, 1'b0, -1, -1, -1, 1'b0);  // clean 0 inside window only
        run_bit(8, 32'h0000_0010, 1'b0, -1, -1, -1, 1'b0);  // 0,1,0

        // prescale too small: cfg_error, no strobes, then recovery
        run_bit(3, 32'hFFFF_FFFF, 1'b0, -1, -1, 2, 1'b1);
        for (int i = 0; i < 3; i++) run_bit(3, 32'hFFFF_FFFF, 1'b0, -1, -1, -1, 1'b0);
        run_bit(8, 32'h0000_0018, 1'b0, -1, -1, 2, 1'b0);   // 1,1,0

        // enable dropped mid-window, then a full window from cleared state
        run_bit(8, 32'hFFFF_FFFF, 1'b0, 4, -1, -1, 1'b0);
        run_bit(8, 32'h0000_0000, 1'b0, -1, -1, -1, 1'b0);

        // reset mid-window with sampled_data = 0, then recovery
        run_bit(8, 32'hFFFF_FFFF, 1'b0, -1, 4, -1, 1'b0);
        run_bit(8, 32'h0000_0008, 1'b0, -1, -1, -1, 1'b0);  // 1,0,0

        // 5-sample instance, prescale 16: window is edges 6..10
        run_bit(16, 32'h0000_04C0, 1'b1, -1, -1, -1, 1'b0); // 1,1,0,0,1
        run_bit(16, 32'hFFFF_F83F, 1'b1, -1, -1, -1, 1'b0); // clean 0 inside window only

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("sb3_drained", sb3.size(), 0);
        check("sb5_drained", sb5.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
